// File: rtl/synth_channel_if.sv
// Host bus bundle for synth_channel: byte address, bidirectional data, direction and strobe.
interface synth_channel_if;
    logic [15:0] BusAddress;
    wire  [7:0]  BusData;
    logic        BusReadWrite;
    logic        BusClock;

    modport master (
        output BusAddress,
        output BusReadWrite,
        output BusClock,
        inout  BusData
    );

    modport slave (
        input  BusAddress,
        input  BusReadWrite,
        input  BusClock,
        inout  BusData
    );
endinterface

// File: rtl/synth_channel.sv
// synth_channel: one bus-programmable DDS voice (saw/square/triangle/noise) with amplitude scaling.
// Optional CHANNEL_READBACK_EN macro adds combinational register readback on BusData.
module synth_channel #(
    parameter logic [15:0] ADDR = 16'h0010
) (
    input  logic           Clock,
    input  logic           Reset,
    synth_channel_if.slave bus,
    output logic [23:0]    Waveform
);
    logic [1:0]  r_bclk_sync;
    logic        r_bclk_prev;
    logic [2:0]  r_ctrl;
    logic [23:0] r_inc;
    logic [23:0] r_pw;
    logic [7:0]  r_amp;
    logic [23:0] r_phase;
    logic [23:0] r_lfsr;

    logic [15:0] w_off;
    logic        w_in_win;
    logic        w_wr;
    logic [24:0] w_sum;
    logic        w_lfsr_fb;
    logic [23:0] w_tri_base;
    logic [23:0] w_raw;
    logic [8:0]  w_amp1;
    logic [32:0] w_prod;
    logic        w_unused_prod;

    // Offset arithmetic wraps mod 2^16, so the window test works for any ADDR alignment.
    assign w_off    = bus.BusAddress - ADDR;
    assign w_in_win = (w_off[15:4] == 12'h000);
    assign w_wr     = r_bclk_sync[1] & ~r_bclk_prev & bus.BusReadWrite & w_in_win;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_bclk_sync <= 2'b00;
            r_bclk_prev <= 1'b0;
            r_ctrl      <= 3'd0;
            r_inc       <= 24'h000000;
            r_pw        <= 24'h800000;
            r_amp       <= 8'hFF;
        end else begin
            r_bclk_sync <= {r_bclk_sync[0], bus.BusClock};
            r_bclk_prev <= r_bclk_sync[1];
            if (w_wr) begin
                case (w_off[3:0])
                    4'h0: r_ctrl         <= bus.BusData[2:0];
                    4'h1: r_inc[7:0]     <= bus.BusData;
                    4'h2: r_inc[15:8]    <= bus.BusData;
                    4'h3: r_inc[23:16]   <= bus.BusData;
                    4'h4: r_pw[7:0]      <= bus.BusData;
                    4'h5: r_pw[15:8]     <= bus.BusData;
                    4'h6: r_pw[23:16]    <= bus.BusData;
                    4'h7: r_amp          <= bus.BusData;
                    default: ;
                endcase
            end
        end
    end

    assign w_sum      = {1'b0, r_phase} + {1'b0, r_inc};
    assign w_lfsr_fb  = r_lfsr[23] ^ r_lfsr[22] ^ r_lfsr[21] ^ r_lfsr[16];
    assign w_tri_base = {r_phase[22:0], 1'b0};

    always_comb begin
        w_raw = 24'h000000;
        unique case (r_ctrl[2:1])
            2'd0: w_raw = r_phase;
            2'd1: w_raw = (r_phase < r_pw) ? 24'hFFFFFF : 24'h000000;
            2'd2: w_raw = r_phase[23] ? ~w_tri_base : w_tri_base;
            2'd3: w_raw = r_lfsr;
        endcase
    end

    // AMP+1 spans 1..256, so AMP=FF is an exact pass-through after the >>8.
    assign w_amp1        = {1'b0, r_amp} + 9'd1;
    assign w_prod        = {9'd0, w_raw} * {24'd0, w_amp1};
    assign w_unused_prod = ^{w_prod[32], w_prod[7:0]};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_phase  <= 24'h000000;
            r_lfsr   <= 24'h000001;
            Waveform <= 24'h000000;
        end else if (r_ctrl[0]) begin
            r_phase  <= w_sum[23:0];
            Waveform <= w_prod[31:8];
            if (w_sum[24]) begin
                r_lfsr <= {r_lfsr[22:0], w_lfsr_fb};
            end
        end else begin
            r_phase  <= 24'h000000;
            Waveform <= 24'h000000;
        end
    end

`ifdef CHANNEL_READBACK_EN
    logic [7:0] w_rd_data;

    always_comb begin
        w_rd_data = 8'h00;
        case (w_off[3:0])
            4'h0: w_rd_data = {5'd0, r_ctrl};
            4'h1: w_rd_data = r_inc[7:0];
            4'h2: w_rd_data = r_inc[15:8];
            4'h3: w_rd_data = r_inc[23:16];
            4'h4: w_rd_data = r_pw[7:0];
            4'h5: w_rd_data = r_pw[15:8];
            4'h6: w_rd_data = r_pw[23:16];
            4'h7: w_rd_data = r_amp;
            default: ;
        endcase
    end

    assign bus.BusData = (bus.BusClock && !bus.BusReadWrite && w_in_win) ? w_rd_data : 8'hzz;
`else
    // Write-only build: BusData is never driven by this channel.
`endif
endmodule

// File: tb/tb_synth_channel.sv
// Self-checking bench for synth_channel: directed literal checks plus randomized bus traffic
// compared every cycle against a behavioural model of the voice.
module tb_synth_channel;
    localparam logic [15:0] C_ADDR = 16'h0010;

    logic        Clock;
    logic        Reset;
    logic [23:0] Waveform;
    logic        r_drv;
    logic [7:0]  r_data;
    logic        r_chk;

    int n_total;
    int n_bad;

    synth_channel_if bus ();

    assign bus.BusData = r_drv ? r_data : 8'hzz;

    synth_channel #(
        .ADDR(C_ADDR)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .bus     (bus),
        .Waveform(Waveform)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural model state.
    longint unsigned m_ctrl, m_inc, m_pw, m_amp, m_phase, m_lfsr, m_wave;
    longint unsigned m_raw, m_sum, m_next_wave;
    int              m_pend;
    logic [15:0]     m_pend_addr;
    logic [7:0]      m_pend_data;

    task automatic model_reset();
        m_ctrl  = 0;
        m_inc   = 0;
        m_pw    = 64'h800000;
        m_amp   = 64'hFF;
        m_phase = 0;
        m_lfsr  = 1;
        m_wave  = 0;
        m_pend  = 0;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        logic [15:0]     off;
        longint unsigned dv;
        off = a - C_ADDR;
        dv  = longint'(d);
        if (off < 16) begin
            case (off)
                0: m_ctrl = dv & 7;
                1: m_inc  = (m_inc & 64'hFFFF00) | dv;
                2: m_inc  = (m_inc & 64'hFF00FF) | (dv << 8);
                3: m_inc  = (m_inc & 64'h00FFFF) | (dv << 16);
                4: m_pw   = (m_pw & 64'hFFFF00) | dv;
                5: m_pw   = (m_pw & 64'hFF00FF) | (dv << 8);
                6: m_pw   = (m_pw & 64'h00FFFF) | (dv << 16);
                7: m_amp  = dv;
                default: ;
            endcase
        end
    endtask

    function automatic longint unsigned model_reg(input logic [15:0] a);
        logic [15:0] off;
        off = a - C_ADDR;
        case (off)
            0: return m_ctrl;
            1: return m_inc & 64'hFF;
            2: return (m_inc >> 8) & 64'hFF;
            3: return (m_inc >> 16) & 64'hFF;
            4: return m_pw & 64'hFF;
            5: return (m_pw >> 8) & 64'hFF;
            6: return (m_pw >> 16) & 64'hFF;
            7: return m_amp;
            default: return 0;
        endcase
    endfunction

    always @(posedge Clock) begin
        if (Reset) begin
            if ((m_ctrl & 1) != 0) begin
                case ((m_ctrl >> 1) & 3)
                    0: m_raw = m_phase;
                    1: m_raw = (m_phase < m_pw) ? 64'hFFFFFF : 64'h0;
                    2: m_raw = (m_phase < 64'h800000) ? 2 * m_phase
                                                       : 64'hFFFFFF - 2 * (m_phase - 64'h800000);
                    default: m_raw = m_lfsr;
                endcase
                m_next_wave = (m_raw * (m_amp + 1)) / 256;
                m_sum = m_phase + m_inc;
                if (m_sum >= 64'h1000000) begin
                    m_lfsr = ((m_lfsr << 1) & 64'hFFFFFF) |
                             longint'($countones(m_lfsr & 64'hE10000) % 2);
                end
                m_phase = m_sum % 64'h1000000;
            end else begin
                m_next_wave = 0;
                m_phase     = 0;
            end
            m_wave = m_next_wave;
            // Strobe crosses a 2-flop synchronizer then an edge detect: write lands on the 3rd edge.
            if (m_pend > 0) begin
                m_pend = m_pend - 1;
                if (m_pend == 0) model_write(m_pend_addr, m_pend_data);
            end
        end
    end

    always @(negedge Clock) begin
        if (r_chk) begin
            n_total = n_total + 1;
            if (Waveform !== m_wave[23:0]) begin
                n_bad = n_bad + 1;
                $display("FAIL wave_model t=%0t got=%h expected=%h", $time, Waveform, m_wave[23:0]);
            end
        end
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_total = n_total + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge Clock);
        #1;
        bus.BusAddress   = a;
        bus.BusReadWrite = 1'b1;
        r_data           = d;
        r_drv            = 1'b1;
        bus.BusClock     = 1'b1;
        m_pend_addr      = a;
        m_pend_data      = d;
        m_pend           = 3;
        repeat (4) @(posedge Clock);
        #1;
        bus.BusClock = 1'b0;
        r_drv        = 1'b0;
        repeat (3) @(posedge Clock);
    endtask

`ifdef CHANNEL_READBACK_EN
    task automatic bus_read(input logic [15:0] a, output logic [7:0] v);
        @(posedge Clock);
        #1;
        bus.BusAddress   = a;
        bus.BusReadWrite = 1'b0;
        r_drv            = 1'b0;
        bus.BusClock     = 1'b1;
        #1;
        v = bus.BusData;
        repeat (2) @(posedge Clock);
        #1;
        bus.BusClock = 1'b0;
        repeat (3) @(posedge Clock);
    endtask
`endif

    logic [23:0] s_samp [0:39];
    logic [23:0] s_prev;
    int          s_idx;
    logic [7:0]  s_rd;
    logic [15:0] s_addr;
    logic [7:0]  s_dat;

    initial begin
        n_total          = 0;
        n_bad            = 0;
        r_chk            = 1'b0;
        r_drv            = 1'b0;
        r_data           = 8'h00;
        bus.BusAddress   = 16'h0000;
        bus.BusReadWrite = 1'b0;
        bus.BusClock     = 1'b0;
        Reset            = 1'b0;
        model_reset();
        repeat (3) @(posedge Clock);
        #3;
        Reset = 1'b1;
        r_chk = 1'b1;
        @(negedge Clock);
        chk("reset_wave", Waveform, 0);
`ifdef CHANNEL_READBACK_EN
        bus_read(16'h0014, s_rd);
        chk("rd_pw_lo", s_rd, 8'h00);
        bus_read(16'h0015, s_rd);
        chk("rd_pw_mid", s_rd, 8'h00);
        bus_read(16'h0016, s_rd);
        chk("rd_pw_hi", s_rd, 8'h80);
`endif

        // Saw climbing by 0x100 per Clock from a stopped phase.
        bus_write(16'h0011, 8'h00);
        bus_write(16'h0012, 8'h01);
        bus_write(16'h0013, 8'h00);
        bus_write(16'h0010, 8'h01);
        @(negedge Clock);
        chk("saw_climb0", Waveform, 24'h000300);
        @(negedge Clock);
        chk("saw_climb1", Waveform, 24'h000400);

        // Saw wrap with a coarse increment.
        bus_write(16'h0010, 8'h00);
        bus_write(16'h0012, 8'h00);
        bus_write(16'h0013, 8'h40);
        bus_write(16'h0010, 8'h01);
        @(negedge Clock);
        chk("saw_pre_wrap", Waveform, 24'hC00000);
        @(negedge Clock);
        chk("saw_wrap", Waveform, 24'h000000);
        @(negedge Clock);
        chk("saw_post_wrap", Waveform, 24'h400000);

        // Square, 50% duty, 16-sample period.
        bus_write(16'h0010, 8'h00);
        bus_write(16'h0013, 8'h10);
        bus_write(16'h0014, 8'h00);
        bus_write(16'h0015, 8'h00);
        bus_write(16'h0016, 8'h80);
        bus_write(16'h0010, 8'h03);
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            s_samp[i] = Waveform;
        end
        s_idx = -1;
        for (int i = 1; i < 20; i++) begin
            if (s_idx < 0 && s_samp[i] == 24'h000000 && s_samp[i-1] == 24'hFFFFFF) s_idx = i;
        end
        chk("sq_edge_found", (s_idx >= 0) ? 1 : 0, 1);
        if (s_idx >= 0) begin
            for (int i = 0; i < 16; i++) begin
                chk("sq_pattern", s_samp[s_idx+i], (i < 8) ? 24'h000000 : 24'hFFFFFF);
            end
        end

        // Saw at half amplitude.
        bus_write(16'h0010, 8'h00);
        bus_write(16'h0013, 8'h00);
        bus_write(16'h0012, 8'h01);
        bus_write(16'h0017, 8'h7F);
        bus_write(16'h0010, 8'h01);
        @(negedge Clock);
        chk("amp_half0", Waveform, 24'h000180);
        @(negedge Clock);
        chk("amp_half1", Waveform, 24'h000200);
        bus_write(16'h0017, 8'hFF);

        // Out-of-window and reserved writes must not touch the channel.
        bus_write(16'h0010, 8'h00);
        bus_write(16'h0011, 8'h5A);
        bus_write(16'h0030, 8'h05);
        bus_write(16'h0031, 8'h33);
        bus_write(16'h0018, 8'hFF);
        repeat (4) @(negedge Clock);
        chk("outside_no_enable", Waveform, 0);
`ifdef CHANNEL_READBACK_EN
        bus_read(16'h0011, s_rd);
        chk("rd_inc_lo", s_rd, 8'h5A);
        bus_read(16'h0010, s_rd);
        chk("rd_ctrl", s_rd, 8'h00);
        bus_read(16'h0018, s_rd);
        chk("rd_reserved", s_rd, 8'h00);
`endif

        // Asynchronous reset in the middle of a running triangle.
        bus_write(16'h0013, 8'h03);
        bus_write(16'h0010, 8'h05);
        repeat (6) @(posedge Clock);
        #3;
        Reset = 1'b0;
        model_reset();
        #1;
        chk("rst_async", Waveform, 0);
        repeat (2) @(posedge Clock);
        #3;
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            chk("rst_hold", Waveform, 0);
        end

        // Randomized traffic against the model.
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                s_addr = 16'h0100 + 16'($urandom_range(0, 255));
            end else begin
                s_addr = C_ADDR + 16'($urandom_range(0, 15));
            end
            s_dat = 8'($urandom_range(0, 255));
            if (s_addr == C_ADDR && $urandom_range(0, 4) != 0) s_dat[0] = 1'b1;
`ifdef CHANNEL_READBACK_EN
            if ($urandom_range(0, 4) == 0) begin
                bus_read(s_addr, s_rd);
                chk("rd_random", s_rd, ((s_addr - C_ADDR) < 16) ? model_reg(s_addr) : 64'h0);
            end else begin
                bus_write(s_addr, s_dat);
            end
`else
            bus_write(s_addr, s_dat);
`endif
            repeat ($urandom_range(0, 25)) @(posedge Clock);
        end

        repeat (3) @(posedge Clock);
        r_chk = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog t=%0t got=running expected=finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/synth_channel.md
Name: synth_channel

Overview:
- One synthesizer voice: a bus-programmable direct-digital-synthesis oscillator with selectable waveform and amplitude scaling.
- Produces an unsigned 24-bit sample stream every Clock.
- Sits on the shared 8-bit host bus; several instances sit at different base addresses.
- Outputs are summed and rescaled by the parent mixer.

Parameters:
- ADDR, 16'h0010, base bus address. The channel decodes the 16-byte window ADDR..ADDR+15.

Ports:
- Clock  input  1  system clock; all state is clocked on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- BusAddress  input  16  host byte address.
- BusData  inout  8  host data. Driven only during reads of this window, else high-Z.
- BusReadWrite  input  1  1 = write (host drives BusData), 0 = read.
- BusClock  input  1  host access strobe, asynchronous to Clock.
- Waveform  output  24  unsigned sample, registered.

Behaviour:
- Register map, as offsets from ADDR:
  - 0x0 CTRL: bit0 EN; bits2:1 WTYPE (0 saw, 1 square, 2 triangle, 3 noise); bits7:3 read 0.
  - 0x1/0x2/0x3 INC low/mid/high byte: 24-bit phase increment.
  - 0x4/0x5/0x6 PW low/mid/high byte: 24-bit square threshold.
  - 0x7 AMP: 8-bit amplitude.
  - 0x8-0xF: reserved. Writes are ignored; reads return 0.
- Reset values (Reset low, asynchronous):
  - CTRL = 0, INC = 0, PW = 24'h800000, AMP = 8'hFF.
  - Phase = 0, LFSR = 24'h000001, Waveform = 0, strobe synchronizer cleared.
- Bus write path:
  - BusClock passes through a 2-flop synchronizer into the Clock domain; a rising edge of the synchronized strobe is detected.
  - On that detect cycle, if BusReadWrite = 1 and BusAddress is in the window, BusData is written to the addressed byte.
  - The host holds address and data stable from BusClock rise for at least 3 Clock cycles.
  - Each byte takes effect immediately. There is no shadowing of multi-byte fields.
  - Back-to-back strobes are each processed, provided BusClock stays low for at least 2 Clock cycles between them.
- Phase accumulator (24 bits):
  - EN = 1: phase <= phase + INC every Clock, wrapping modulo 2^24.
  - EN = 0: phase <= 0.
  - A wrap is a carry out of bit 23.
- Noise LFSR:
  - 24-bit Fibonacci, taps 24, 23, 22, 17.
  - Shifts once per wrap, and only while EN = 1.
- Raw wave, derived from the current phase p:
  - saw = p.
  - square = 24'hFFFFFF if p < PW, else 0.
    - PW = 0 gives constant 0.
  - triangle = {p[22:0],0} when p[23] = 0; otherwise the bitwise inverse of {p[22:0],0}.
  - noise = LFSR value.
- Output:
  - Waveform <= (raw * (AMP+1)) >> 8, computed with 33-bit intermediate precision.
  - AMP = 8'hFF passes raw unchanged.
  - Forced to 0 when EN = 0.
  - Latency: Waveform reflects the phase register of the previous Clock.
- A WTYPE change takes effect on the next Clock without resetting phase.
- Reset mid-operation returns everything to reset values immediately.

Optional Feature:
- CHANNEL_READBACK_EN.
- Defined:
  - While BusClock = 1, BusReadWrite = 0 and BusAddress is in the window, BusData is combinationally driven with the addressed register. Reserved offsets read 0.
  - Otherwise BusData is high-Z.
- Undefined: the channel is write-only and BusData is never driven.

Test Plan:
- Reset release -> Waveform = 0. A read at 0x0014 (with the feature enabled) returns 0x00, then 0x0015 returns 0x00 and 0x0016 returns 0x80.
- Write INC = 0x000100 then CTRL = 0x01 at ADDR = 0x0010 -> Waveform climbs by 0x000100 per Clock, starting from 0, and wraps from 0xFFFF00 to 0x000000.
- CTRL = 0x03, INC = 0x100000, PW = 0x800000 -> Waveform is 0xFFFFFF for 8 Clocks, then 0 for 8 Clocks, repeating.
- Saw running, AMP = 0x7F -> each sample equals saw*128>>8, i.e. half of the unscaled value.
- Write 0x05 to 0x0030 (outside the window) -> no register changes. Readback at 0x0011 returns the last INC low byte written.
- Assert Reset low mid-run -> Waveform = 0 asynchronously. After release, CTRL = 0, so the output stays 0 until re-enabled.
